ntt_bf_sched: RTL and testbench

NTT_BF_SCHED -- requirements
Module: ntt_bf_sched

---
 rtl/ntt_pkg.sv | 21 ++
 rtl/ntt_addr_gen.sv | 33 +++
 rtl/ntt_bf_sched.sv | 158 +++++++++++++++
 tb/tb_ntt_bf_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly scheduler: state encoding,
// default transform geometry and the stage-number width helper.
package ntt_pkg;

  localparam int N_LOG2_DEF = 8;
  localparam int BF_LAT_DEF = 4;
  localparam int ADDR_W     = N_LOG2_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of the stage number; kept at least one bit for tiny transforms.
  function automatic int stage_w(input int n_log2);
    return (n_log2 > 1) ? $clog2(n_log2) : 1;
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Operand address pair and twiddle index for butterfly j of a given stage.
// Stage s splits the array into blocks of 2*len with len = N >> (s+1); the
// j-th butterfly pairs element off with off+len inside block j/len.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int STG_W  = stage_w(N_LOG2)
) (
  input  logic [STG_W-1:0]  stage,
  input  logic [N_LOG2-1:0] j,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-1:0] tw_idx
);

  logic [N_LOG2-1:0] one;
  logic [N_LOG2-1:0] len;
  logic [N_LOG2-1:0] grp;
  int                sh;

  // Block index, in-block offset and twiddle base for the current stage.
  always_comb begin
    sh     = N_LOG2 - 1 - int'(stage);
    one    = N_LOG2'(1);
    len    = one << sh;
    grp    = j >> sh;
    addr_a = (grp << (sh + 1)) | (j & (len - one));
    addr_b = addr_a + len;
    tw_idx = (one << stage) + grp;
  end

endmodule

// File: rtl/ntt_bf_sched.sv
// Forward-NTT butterfly scheduler. Walks N_LOG2 stages of N/2 butterflies
// through a shared butterfly unit, then tracks each accepted pair through a
// BF_LAT-deep delay line to strobe its write-back addresses.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_ISSUE | presenting butterfly j of the current stage
//   ST_DRAIN | stage fully issued, waiting for in-flight write-backs
//   ST_DONE  | one-cycle completion pulse
module ntt_bf_sched
  import ntt_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int BF_LAT = BF_LAT_DEF,
  parameter int STG_W  = stage_w(N_LOG2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-1:0] tw_idx,
  output logic [STG_W-1:0]  stage,
  output logic              wb_valid,
  output logic [N_LOG2-1:0] wb_addr_a,
  output logic [N_LOG2-1:0] wb_addr_b
);

  localparam int                AW       = N_LOG2;
  localparam int                HALF     = 1 << (N_LOG2 - 1);
  localparam int                CNT_W    = $clog2(BF_LAT + 2);
  localparam logic [AW-1:0]     LAST_J   = AW'(HALF - 1);
  localparam logic [STG_W-1:0]  LAST_STG = STG_W'(N_LOG2 - 1);

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     j_q;
  logic [STG_W-1:0]  stage_q;
  logic [CNT_W-1:0]  inflight;
  logic              issuing;
  logic              accept;
  logic              last_j;
  logic              drained;
  logic [AW-1:0]     gen_a;
  logic [AW-1:0]     gen_b;
  logic [AW-1:0]     gen_tw;
  logic [BF_LAT-1:0] vld_pipe;
  logic [AW-1:0]     pa_pipe [BF_LAT];
  logic [AW-1:0]     pb_pipe [BF_LAT];

  assign issuing = (state == ST_ISSUE);
  assign accept  = issuing && bf_ready;
  assign last_j  = (j_q == LAST_J);
  assign drained = (inflight == '0);

  ntt_addr_gen #(
    .N_LOG2 (N_LOG2),
    .STG_W  (STG_W)
  ) u_addr_gen (
    .stage  (stage_q),
    .j      (j_q),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: stage ends on the last accepted butterfly, and the
  // next stage waits until every write-back of this one has emerged.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: if (accept && last_j) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (drained) state_nxt = (stage_q == LAST_STG) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Butterfly index and stage counters; j only advances on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      j_q     <= '0;
      stage_q <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        j_q     <= '0;
        stage_q <= '0;
      end else if (accept) begin
        j_q <= last_j ? '0 : j_q + AW'(1);
      end else if (state == ST_DRAIN && drained && stage_q != LAST_STG) begin
        stage_q <= stage_q + STG_W'(1);
      end else if (state == ST_DONE) begin
        stage_q <= '0;
      end
    end
  end

  // Write-back delay line: each accepted pair reappears BF_LAT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        pa_pipe[i] <= '0;
        pb_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= accept;
      pa_pipe[0]  <= gen_a;
      pb_pipe[0]  <= gen_b;
      for (int i = 1; i < BF_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pa_pipe[i]  <= pa_pipe[i-1];
        pb_pipe[i]  <= pb_pipe[i-1];
      end
    end
  end

  // In-flight count: issue and write-back in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, wb_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Read-side addresses are forced to zero outside ISSUE so reset and idle
  // present a quiet bus.
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign bf_valid  = issuing;
  assign addr_a    = issuing ? gen_a  : '0;
  assign addr_b    = issuing ? gen_b  : '0;
  assign tw_idx    = issuing ? gen_tw : '0;
  assign stage     = stage_q;
  assign wb_valid  = vld_pipe[BF_LAT-1];
  assign wb_addr_a = pa_pipe[BF_LAT-1];
  assign wb_addr_b = pb_pipe[BF_LAT-1];

endmodule

// File: tb/tb_ntt_bf_sched.sv
// Directed bench for the NTT butterfly scheduler: default geometry
// (N=256, latency 4) plus a tiny N=8, latency 1 instance.
module tb_ntt_bf_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       rst, start, bf_ready;
  logic       busy, done, bf_valid, wb_valid;
  logic [7:0] addr_a, addr_b, tw_idx, wb_addr_a, wb_addr_b;
  logic [2:0] stage;

  // Small instance
  logic       rst_s, start_s, ready_s;
  logic       busy_s, done_s, bfv_s, wbv_s;
  logic [2:0] a_s, b_s, tw_s, wba_s, wbb_s;
  logic [1:0] stage_s;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  ntt_bf_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .addr_a(addr_a), .addr_b(addr_b),
    .tw_idx(tw_idx), .stage(stage), .wb_valid(wb_valid),
    .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b)
  );

  ntt_bf_sched #(.N_LOG2(3), .BF_LAT(1)) dut_s (
    .clk(clk), .rst(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
    .bf_valid(bfv_s), .bf_ready(ready_s), .addr_a(a_s), .addr_b(b_s),
    .tw_idx(tw_s), .stage(stage_s), .wb_valid(wbv_s),
    .wb_addr_a(wba_s), .wb_addr_b(wbb_s)
  );

  // Expected pair written as block/offset arithmetic.
  function automatic int exp_a(int nl, int s, int j);
    int len = 1 << (nl - 1 - s);
    return (j / len) * 2 * len + (j % len);
  endfunction
  function automatic int exp_b(int nl, int s, int j);
    return exp_a(nl, s, j) + (1 << (nl - 1 - s));
  endfunction
  function automatic int exp_tw(int nl, int s, int j);
    return (1 << s) + j / (1 << (nl - 1 - s));
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bf_ready = 1'b1;
    rst_s = 1'b1; start_s = 1'b0; ready_s = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (bf_valid !== 1'b0) begin errors++; $display("FAIL reset_bf_valid: got %b expected 0", bf_valid); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    checks++; if ({addr_a, addr_b, tw_idx} !== 24'h0) begin errors++; $display("FAIL reset_addr: got %0d/%0d/%0d expected 0/0/0", addr_a, addr_b, tw_idx); end
    checks++; if ({wb_addr_a, wb_addr_b} !== 16'h0) begin errors++; $display("FAIL reset_wb_addr: got %0d/%0d expected 0/0", wb_addr_a, wb_addr_b); end
    checks++; if (stage !== 3'd0) begin errors++; $display("FAIL reset_stage: got %0d expected 0", stage); end
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timing();
    int bad_done = 0;
    start = 1'b1; cyc = 0;
    while (cyc < 1067) begin
      step();
      start = (cyc == 1065);
      if (done !== (cyc == 1065)) bad_done++;
      case (cyc)
        1: begin
          checks++; if (bf_valid !== 1'b1) begin errors++; $display("FAIL c1_valid: got %b expected 1", bf_valid); end
          checks++; if ({addr_a, addr_b, tw_idx} !== {8'd0, 8'd128, 8'd1}) begin errors++; $display("FAIL c1_addr: got %0d/%0d/%0d expected 0/128/1", addr_a, addr_b, tw_idx); end
        end
        4: begin
          checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL c4_wb: got %b expected 0", wb_valid); end
        end
        5: begin
          checks++; if ({wb_valid, wb_addr_a, wb_addr_b} !== {1'b1, 8'd0, 8'd128}) begin errors++; $display("FAIL c5_wb: got %b %0d/%0d expected 1 0/128", wb_valid, wb_addr_a, wb_addr_b); end
        end
        128: begin
          checks++; if ({bf_valid, addr_a, addr_b} !== {1'b1, 8'd127, 8'd255}) begin errors++; $display("FAIL c128_addr: got %b %0d/%0d expected 1 127/255", bf_valid, addr_a, addr_b); end
        end
        129, 133: begin
          checks++; if (bf_valid !== 1'b0) begin errors++; $display("FAIL c%0d_drain: got %b expected 0", cyc, bf_valid); end
        end
        134: begin
          checks++; if ({bf_valid, stage, addr_a, addr_b, tw_idx} !== {1'b1, 3'd1, 8'd0, 8'd64, 8'd2}) begin errors++; $display("FAIL c134_stage1: got %b s%0d %0d/%0d/%0d expected 1 s1 0/64/2", bf_valid, stage, addr_a, addr_b, tw_idx); end
        end
        1059: begin
          checks++; if ({bf_valid, stage, addr_a, addr_b, tw_idx} !== {1'b1, 3'd7, 8'd254, 8'd255, 8'd255}) begin errors++; $display("FAIL c1059_last: got %b s%0d %0d/%0d/%0d expected 1 s7 254/255/255", bf_valid, stage, addr_a, addr_b, tw_idx); end
        end
        1065: begin
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL c1065_busy: got %b expected 1", busy); end
        end
        1066, 1067: begin
          checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c%0d_busy: got %b expected 0", cyc, busy); end
        end
        default: ;
      endcase
    end
    start = 1'b0;
    checks++; if (bad_done != 0) begin errors++; $display("FAIL done_pulse: got %0d off-schedule cycles expected 0", bad_done); end
  endtask

  task automatic test_random_ready();
    int q_due[$];
    int q_a[$];
    int q_b[$];
    int q_s[$];
    int wb_cnt[8];
    int s_exp = 0;
    int j_exp = 0;
    bit got_done = 0;
    for (int i = 0; i < 8; i++) wb_cnt[i] = 0;
    start = 1'b1; cyc = 0;
    while (cyc < 6000 && !got_done) begin
      step();
      start = 1'b0;
      if (wb_valid === 1'b1) begin
        checks++;
        if (q_due.size() == 0) begin
          errors++; $display("FAIL rr_wb_extra: got wb at cycle %0d expected none", cyc);
        end else if (q_due[0] != cyc || int'(wb_addr_a) != q_a[0] || int'(wb_addr_b) != q_b[0]) begin
          errors++; $display("FAIL rr_wb: got cyc %0d %0d/%0d expected cyc %0d %0d/%0d", cyc, wb_addr_a, wb_addr_b, q_due[0], q_a[0], q_b[0]);
          void'(q_due.pop_front()); void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_s.pop_front());
        end else begin
          wb_cnt[q_s[0]]++;
          void'(q_due.pop_front()); void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_s.pop_front());
        end
      end else if (q_due.size() != 0 && q_due[0] <= cyc) begin
        checks++; errors++;
        $display("FAIL rr_wb_missing: got no wb at cycle %0d expected %0d/%0d", cyc, q_a[0], q_b[0]);
        void'(q_due.pop_front()); void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_s.pop_front());
      end
      bf_ready = 1'($urandom_range(0, 1));
      if (bf_valid === 1'b1) begin
        if (j_exp == 0 && s_exp > 0) begin
          checks++; if (q_due.size() != 0) begin errors++; $display("FAIL rr_stage_overlap: got %0d pending expected 0", q_due.size()); end
        end
        checks++;
        if (s_exp > 7 || int'(stage) != s_exp || int'(addr_a) != exp_a(8, s_exp, j_exp) ||
            int'(addr_b) != exp_b(8, s_exp, j_exp) || int'(tw_idx) != exp_tw(8, s_exp, j_exp)) begin
          errors++;
          $display("FAIL rr_issue: got s%0d %0d/%0d/%0d expected s%0d j%0d", stage, addr_a, addr_b, tw_idx, s_exp, j_exp);
        end
        if (bf_ready) begin
          q_due.push_back(cyc + 4); q_a.push_back(int'(addr_a)); q_b.push_back(int'(addr_b)); q_s.push_back(s_exp & 7);
          if (j_exp == 127) begin j_exp = 0; s_exp++; end
          else j_exp++;
        end
      end
      if (done === 1'b1) got_done = 1;
    end
    bf_ready = 1'b1;
    checks++; if (!got_done) begin errors++; $display("FAIL rr_timeout: got no done expected done within 6000 cycles"); end
    checks++; if (s_exp != 8) begin errors++; $display("FAIL rr_stages: got %0d expected 8", s_exp); end
    checks++; if (q_due.size() != 0) begin errors++; $display("FAIL rr_pending: got %0d expected 0", q_due.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (wb_cnt[i] != 128) begin errors++; $display("FAIL rr_wb_count_s%0d: got %0d expected 128", i, wb_cnt[i]); end
    end
    step();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; cyc = 0;
    while (cyc < 450) begin
      step();
      start = 1'b0;
    end
    checks++; if ({bf_valid, stage} !== {1'b1, 3'd3}) begin errors++; $display("FAIL rm_pre: got %b s%0d expected 1 s3", bf_valid, stage); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({busy, bf_valid} !== 2'b00) begin errors++; $display("FAIL rm_idle: got busy %b valid %b expected 0 0", busy, bf_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rm_wb_%0d: got %b expected 0", i, wb_valid); end
      if (i < 3) step();
    end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({bf_valid, stage, addr_a, addr_b, tw_idx} !== {1'b1, 3'd0, 8'd0, 8'd128, 8'd1}) begin errors++; $display("FAIL rm_restart: got %b s%0d %0d/%0d/%0d expected 1 s0 0/128/1", bf_valid, stage, addr_a, addr_b, tw_idx); end
    step();
    checks++; if ({addr_a, addr_b} !== {8'd1, 8'd129}) begin errors++; $display("FAIL rm_restart_j1: got %0d/%0d expected 1/129", addr_a, addr_b); end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_start_held();
    int n_done = 0;
    int first_done = -1;
    start = 1'b1; cyc = 0;
    while (cyc < 1067) begin
      step();
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
      if (cyc == 500) begin
        checks++; if ({busy, stage} !== {1'b1, 3'd3}) begin errors++; $display("FAIL sh_mid: got busy %b s%0d expected 1 s3", busy, stage); end
      end
      if (cyc == 1066) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sh_idle: got %b expected 0", busy); end
      end
    end
    checks++; if (n_done != 1 || first_done != 1065) begin errors++; $display("FAIL sh_done: got %0d pulses first %0d expected 1 at 1065", n_done, first_done); end
    checks++; if ({bf_valid, stage, addr_a, addr_b, tw_idx} !== {1'b1, 3'd0, 8'd0, 8'd128, 8'd1}) begin errors++; $display("FAIL sh_second: got %b s%0d %0d/%0d/%0d expected 1 s0 0/128/1", bf_valid, stage, addr_a, addr_b, tw_idx); end
    start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_small();
    int tbl_a[12]  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int tbl_b[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int tbl_tw[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
    int bad_valid = 0;
    int bad_done  = 0;
    rst_s = 1'b0;
    step();
    start_s = 1'b1; cyc = 0;
    while (cyc < 20) begin
      int s, p, k;
      bit exp_v;
      step();
      start_s = 1'b0;
      s = (cyc - 1) / 6; p = (cyc - 1) % 6; k = s * 4 + p;
      exp_v = (s < 3) && (p < 4);
      if (bfv_s !== exp_v) bad_valid++;
      if (done_s !== (cyc == 19)) bad_done++;
      if (exp_v) begin
        checks++;
        if ({a_s, b_s, tw_s} !== {3'(tbl_a[k]), 3'(tbl_b[k]), 3'(tbl_tw[k])}) begin
          errors++; $display("FAIL small_pair_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", k, a_s, b_s, tw_s, tbl_a[k], tbl_b[k], tbl_tw[k]);
        end
      end
      s = (cyc - 2) / 6; p = (cyc - 2) % 6; k = s * 4 + p;
      if (cyc >= 2 && s < 3 && p < 4) begin
        checks++;
        if ({wbv_s, wba_s, wbb_s} !== {1'b1, 3'(tbl_a[k]), 3'(tbl_b[k])}) begin
          errors++; $display("FAIL small_wb_%0d: got %b %0d/%0d expected 1 %0d/%0d", k, wbv_s, wba_s, wbb_s, tbl_a[k], tbl_b[k]);
        end
      end
    end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL small_valid: got %0d wrong cycles expected 0", bad_valid); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL small_done: got %0d wrong cycles expected done only at 19", bad_done); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL small_busy_end: got %b expected 0", busy_s); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_random_ready();
    test_reset_mid();
    test_start_held();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
